// File: rtl/gpr_file_mp.sv
// gpr_file_mp: multi-port general-purpose register file.
// - Configurable width, depth and read-port count.
// - Two write ports: port 0 = writeback, port 1 = late / long-latency return.
//   When both hit the same register, port 1 wins.
// - Pending-write scoreboard (one bit per register) for hazard detection.
// - Registered write-collision flag.
// - Optional macro GPR_BYPASS_EN: write-through forwarding from the write
//   ports to the read ports in the same cycle. Register state is the same
//   with or without it.
// - Reset: synchronous, active-low.

module gpr_file_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [1:0]             wr_en,
    input  logic [2*AW-1:0]        wr_addr,
    input  logic [2*XLEN-1:0]      wr_data,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_rd,
    output logic                   wr_conflict
);

    // Storage and scoreboard state
    logic [XLEN-1:0]  regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;

    // Unpacked per-port views of the write bus
    logic [AW-1:0]    wa [2];
    logic [XLEN-1:0]  wd [2];
    logic [1:0]       wr_ok;
    logic             issue_ok;
    logic             collide;

    // Read-path working variables
    logic [AW-1:0]    ra;
    logic [XLEN-1:0]  rdat;
    logic             rbusy;
`ifdef GPR_BYPASS_EN
    logic             hit;
`endif

    // Register 0 is hard-wired to zero when ZERO_REG is set.
    function automatic logic suppressed(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Decode the write ports and the issue into "accepted" qualifiers.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wa[p]    = wr_addr[p*AW +: AW];
            wd[p]    = wr_data[p*XLEN +: XLEN];
            wr_ok[p] = wr_en[p] && !suppressed(wa[p]);
        end
        issue_ok = issue_en && !suppressed(issue_rd);
        collide  = wr_ok[0] && wr_ok[1] && (wa[0] == wa[1]);
    end

    // Scoreboard next state: writes retire producers, then a new issue
    // marks its destination; the issue is applied last so it wins.
    always_comb begin
        pending_nxt = pending;
        for (int p = 0; p < 2; p++) begin
            if (wr_ok[p]) begin
                pending_nxt[wa[p]] = 1'b0;
            end
        end
        if (issue_ok) begin
            pending_nxt[issue_rd] = 1'b1;
        end
    end

    // Register array update; port 1 is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (wr_ok[0]) begin
                regs[wa[0]] <= wd[0];
            end
            if (wr_ok[1]) begin
                regs[wa[1]] <= wd[1];
            end
        end
    end

    // Scoreboard and collision flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            pending     <= pending_nxt;
            wr_conflict <= collide;
        end
    end

    // Combinational read ports: data and busy from pre-edge state, with
    // optional same-cycle forwarding from the write ports.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rdat    = '0;
        rbusy   = 1'b0;
`ifdef GPR_BYPASS_EN
        hit     = 1'b0;
`endif
        for (int i = 0; i < NUM_RD; i++) begin
            ra    = rd_addr[i*AW +: AW];
            rdat  = regs[ra];
            rbusy = pending[ra];
`ifdef GPR_BYPASS_EN
            hit = 1'b0;
            // Port 1 is checked second so its data takes precedence.
            for (int p = 0; p < 2; p++) begin
                if (wr_ok[p] && (wa[p] == ra)) begin
                    rdat = wd[p];
                    hit  = 1'b1;
                end
            end
            // The value is arriving now, so no hazard remains unless a new
            // producer is being issued to the same register.
            if (hit && !(issue_ok && (issue_rd == ra))) begin
                rbusy = 1'b0;
            end
`endif
            if (suppressed(ra)) begin
                rdat  = '0;
                rbusy = 1'b0;
            end
            rd_data[i*XLEN +: XLEN] = rdat;
            rd_busy[i]              = rbusy;
        end
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Testbench for gpr_file_mp.
// - Main instance: default parameters (XLEN=32, DEPTH=32, NUM_RD=2, ZERO_REG=1).
// - Second instance: XLEN=64, DEPTH=16, NUM_RD=3, ZERO_REG=0.
// - Every cycle of the main instance is compared against a behavioural model.
//   The model holds an array of register values and an array of pending flags.
// - Directed steps are followed by a randomized phase.
// - Expectations follow GPR_BYPASS_EN when it is defined.

module tb_gpr_file_mp;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        wr_conflict;

    // ---------------- sweep DUT signals ----------------
    logic [11:0]  s_rd_addr;
    logic [191:0] s_rd_data;
    logic [2:0]   s_rd_busy;
    logic [1:0]   s_wr_en;
    logic [7:0]   s_wr_addr;
    logic [127:0] s_wr_data;
    logic         s_issue_en;
    logic [3:0]   s_issue_rd;
    logic         s_wr_conflict;

    gpr_file_mp u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .wr_conflict (wr_conflict)
    );

    gpr_file_mp #(
        .XLEN     (64),
        .DEPTH    (16),
        .NUM_RD   (3),
        .ZERO_REG (0)
    ) u_dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (s_rd_addr),
        .rd_data     (s_rd_data),
        .rd_busy     (s_rd_busy),
        .wr_en       (s_wr_en),
        .wr_addr     (s_wr_addr),
        .wr_data     (s_wr_data),
        .issue_en    (s_issue_en),
        .issue_rd    (s_issue_rd),
        .wr_conflict (s_wr_conflict)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    // ---------------- reference model (main instance) ----------------
    logic [31:0] m_reg  [32];
    logic        m_pend [32];
    logic        m_conf;
    bit          model_ok = 1'b0;

    // Expected read data for an address under the current inputs.
    function automatic logic [31:0] exp_data(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'h0;
        v = m_reg[a];
`ifdef GPR_BYPASS_EN
        if (wr_en[0] && wr_addr[4:0] == a) v = wr_data[31:0];
        if (wr_en[1] && wr_addr[9:5] == a) v = wr_data[63:32];
`endif
        return v;
    endfunction

    // Expected busy flag for an address under the current inputs.
    function automatic logic exp_busy(input logic [4:0] a);
        logic b;
        if (a == 5'd0) return 1'b0;
        b = m_pend[a];
`ifdef GPR_BYPASS_EN
        if (((wr_en[0] && wr_addr[4:0] == a) || (wr_en[1] && wr_addr[9:5] == a)) &&
            !(issue_en && issue_rd == a))
            b = 1'b0;
`endif
        return b;
    endfunction

    // Advance the model by one rising edge using the current inputs.
    task automatic model_update();
        logic [4:0] a0, a1;
        logic       ok0, ok1;
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[r]  = 32'h0;
                m_pend[r] = 1'b0;
            end
            m_conf = 1'b0;
        end else begin
            a0  = wr_addr[4:0];
            a1  = wr_addr[9:5];
            ok0 = wr_en[0] && (a0 != 5'd0);
            ok1 = wr_en[1] && (a1 != 5'd0);
            m_conf = ok0 && ok1 && (a0 == a1);
            if (ok0) m_reg[a0] = wr_data[31:0];
            if (ok1) m_reg[a1] = wr_data[63:32];
            if (ok0) m_pend[a0] = 1'b0;
            if (ok1) m_pend[a1] = 1'b0;
            if (issue_en && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
        end
        model_ok = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] we,
                         input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input logic ie, input logic [4:0] ir,
                         input logic [4:0] r0, input logic [4:0] r1);
        wr_en    = we;
        wr_addr  = {a1, a0};
        wr_data  = {d1, d0};
        issue_en = ie;
        issue_rd = ir;
        rd_addr  = {r1, r0};
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
    endtask

    // Compare every main-instance output with the model, then take one clock.
    task automatic step();
        #2;
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                check("rd_data_model", {32'h0, rd_data[i*32 +: 32]}, {32'h0, exp_data(rd_addr[i*5 +: 5])});
                check("rd_busy_model", {63'h0, rd_busy[i]}, {63'h0, exp_busy(rd_addr[i*5 +: 5])});
            end
            check("wr_conflict_model", {63'h0, wr_conflict}, {63'h0, m_conf});
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n      = 1'b0;
        s_rd_addr  = '0;
        s_wr_en    = '0;
        s_wr_addr  = '0;
        s_wr_data  = '0;
        s_issue_en = 1'b0;
        s_issue_rd = '0;
        drive(2'b11, 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
        @(negedge clk);

        // Reset held two cycles while both ports try to write reg5
        step();
        step();
        rst_n = 1'b1;
        idle(5'd5, 5'd1);
        #1;
        check("reset_reg5", {32'h0, rd_data[31:0]}, 64'h0);
        check("reset_busy", {62'h0, rd_busy}, 64'h0);
        check("reset_conflict", {63'h0, wr_conflict}, 64'h0);
        step();

        // Basic write and register 0 suppression
        drive(2'b01, 5'd3, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        drive(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
        #1;
        check("write_reg3", {32'h0, rd_data[31:0]}, 64'h12345678);
        step();
        idle(5'd0, 5'd3);
        #1;
        check("zero_reg", {32'h0, rd_data[31:0]}, 64'h0);
        step();

        // Write collision on reg7
        drive(2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222, 1'b0, 5'd0, 5'd7, 5'd0);
        step();
        idle(5'd7, 5'd0);
        #1;
        check("collide_data", {32'h0, rd_data[31:0]}, 64'h2222);
        check("collide_flag", {63'h0, wr_conflict}, 64'h1);
        step();
        #1;
        check("collide_flag_clear", {63'h0, wr_conflict}, 64'h0);
        step();

        // Scoreboard on reg9
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        step();
        idle(5'd9, 5'd9);
        #1;
        check("issue_busy", {62'h0, rd_busy}, 64'h3);
        step();
        drive(2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd0);
        #1;
`ifdef GPR_BYPASS_EN
        check("busy_during_write", {63'h0, rd_busy[0]}, 64'h0);
`else
        check("busy_during_write", {63'h0, rd_busy[0]}, 64'h1);
`endif
        step();
        idle(5'd9, 5'd0);
        #1;
        check("busy_cleared", {63'h0, rd_busy[0]}, 64'h0);
        step();
        drive(2'b01, 5'd9, 32'hAB, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        step();
        idle(5'd9, 5'd0);
        #1;
        check("issue_wins", {63'h0, rd_busy[0]}, 64'h1);
        step();

        // Same-cycle read and write on reg4
        drive(2'b01, 5'd4, 32'hA, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        drive(2'b01, 5'd4, 32'hB, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
        #1;
`ifdef GPR_BYPASS_EN
        check("rw_same_cycle", {32'h0, rd_data[31:0]}, 64'hB);
`else
        check("rw_same_cycle", {32'h0, rd_data[31:0]}, 64'hA);
`endif
        step();
        idle(5'd4, 5'd0);
        #1;
        check("rw_next_cycle", {32'h0, rd_data[31:0]}, 64'hB);
        step();
        drive(2'b11, 5'd4, 32'hC, 5'd4, 32'hD, 1'b0, 5'd0, 5'd4, 5'd4);
        #1;
`ifdef GPR_BYPASS_EN
        check("rw_both_ports", rd_data, 64'h0000000D_0000000D);
`else
        check("rw_both_ports", rd_data, 64'h0000000B_0000000B);
`endif
        step();
        idle(5'd4, 5'd4);
        #1;
        check("rw_both_after", rd_data, 64'h0000000D_0000000D);
        step();

        // Randomized phase with occasional mid-run resets
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            drive(2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)));
            step();
        end
        rst_n = 1'b1;
        idle(5'd0, 5'd0);
        step();

        // Second instance: reg0 is ordinary; three read ports read at once
        s_wr_en    = 2'b11;
        s_wr_addr  = {4'd15, 4'd0};
        s_wr_data  = {64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
        s_issue_en = 1'b1;
        s_issue_rd = 4'd0;
        step();
        s_wr_en    = 2'b01;
        s_wr_addr  = {4'd0, 4'd7};
        s_wr_data  = {64'h0, 64'h5555AAAA5555AAAA};
        s_issue_en = 1'b0;
        step();
        s_wr_en   = 2'b00;
        s_rd_addr = {4'd7, 4'd15, 4'd0};
        #1;
        check("sweep_p0_reg0", s_rd_data[63:0], 64'h0123456789ABCDEF);
        check("sweep_p1_reg15", s_rd_data[127:64], 64'hFEDCBA9876543210);
        check("sweep_p2_reg7", s_rd_data[191:128], 64'h5555AAAA5555AAAA);
        check("sweep_busy", {61'h0, s_rd_busy}, 64'h1);
        check("sweep_conflict", {63'h0, s_wr_conflict}, 64'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
